// File: rtl/svga_vram_slot_arbiter.sv
// Time-slot arbiter for the single-port video RAM: display fetch owns phases 1-3,
// the CPU owns phases 5-7 and also phases 1-3 whenever the display is idle.
module svga_vram_slot_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              phase_sync,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic [2:0]        phase
);

    typedef enum logic [1:0] {
        ACC_NONE   = 2'd0,
        ACC_DISP   = 2'd1,
        ACC_CPU_RD = 2'd2,
        ACC_CPU_WR = 2'd3
    } access_t;

    logic [2:0]        phase_r;
    access_t           grant_s;
    access_t           stage0_r;
    access_t           stage1_r;
    logic [ADDR_W-1:0] vram_addr_r;
    logic              vram_we_r;
    logic [DATA_W-1:0] vram_wdata_r;
    logic [DATA_W-1:0] fetch_data_r;
    logic              fetch_valid_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic              cpu_ack_r;

    // Window decision, only taken on the edges that end phase 0 and phase 4
    always_comb begin
        grant_s = ACC_NONE;
        if (phase_r == 3'd0) begin
            if (fetch_en) begin
                grant_s = ACC_DISP;
            end else if (cpu_req) begin
                grant_s = cpu_we ? ACC_CPU_WR : ACC_CPU_RD;
            end else begin
                grant_s = ACC_NONE;
            end
        end else if (phase_r == 3'd4) begin
            if (cpu_req) begin
                grant_s = cpu_we ? ACC_CPU_WR : ACC_CPU_RD;
            end else begin
                grant_s = ACC_NONE;
            end
        end else begin
            grant_s = ACC_NONE;
        end
    end

    // Slot phase counter; phase_sync realigns to the character boundary
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            phase_r <= 3'd0;
        end else if (phase_sync) begin
            phase_r <= 3'd0;
        end else begin
            phase_r <= phase_r + 3'd1;
        end
    end

    // RAM address port and access pipeline tracking (independent of phase)
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            stage0_r     <= ACC_NONE;
            stage1_r     <= ACC_NONE;
            vram_addr_r  <= '0;
            vram_we_r    <= 1'b0;
            vram_wdata_r <= '0;
        end else begin
            stage0_r  <= grant_s;
            stage1_r  <= stage0_r;
            vram_we_r <= (grant_s == ACC_CPU_WR);
            case (grant_s)
                ACC_DISP:   vram_addr_r <= fetch_addr;
                ACC_CPU_RD: vram_addr_r <= cpu_addr;
                ACC_CPU_WR: begin
                    vram_addr_r  <= cpu_addr;
                    vram_wdata_r <= cpu_wdata;
                end
                default:    vram_addr_r <= vram_addr_r;
            endcase
        end
    end

    // Capture of RAM read data at the end of the read cycle, plus strobes
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            fetch_data_r  <= '0;
            fetch_valid_r <= 1'b0;
            cpu_rdata_r   <= '0;
            cpu_ack_r     <= 1'b0;
        end else begin
            fetch_valid_r <= (stage1_r == ACC_DISP);
            cpu_ack_r     <= (stage1_r == ACC_CPU_RD) || (stage1_r == ACC_CPU_WR);
            if (stage1_r == ACC_DISP) begin
                fetch_data_r <= vram_rdata;
            end
            if (stage1_r == ACC_CPU_RD) begin
                cpu_rdata_r <= vram_rdata;
            end
        end
    end

    assign phase       = phase_r;
    assign vram_addr   = vram_addr_r;
    assign vram_we     = vram_we_r;
    assign vram_wdata  = vram_wdata_r;
    assign fetch_data  = fetch_data_r;
    assign fetch_valid = fetch_valid_r;
    assign cpu_rdata   = cpu_rdata_r;
    assign cpu_ack     = cpu_ack_r;

endmodule

// File: tb/tb_svga_vram_slot_arbiter.sv
// Bench for svga_vram_slot_arbiter: directed cycle table, hand-written corner
// sequences, then randomized traffic against a slot-schedule reference model.
module tb_svga_vram_slot_arbiter;

    logic        pixel_clock;
    logic        reset;
    logic        phase_sync;
    logic        fetch_en;
    logic [12:0] fetch_addr;
    logic [7:0]  fetch_data;
    logic        fetch_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [2:0]  phase;

    svga_vram_slot_arbiter dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .phase_sync  (phase_sync),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .vram_addr   (vram_addr),
        .vram_we     (vram_we),
        .vram_wdata  (vram_wdata),
        .vram_rdata  (vram_rdata),
        .phase       (phase)
    );

    initial begin
        pixel_clock = 1'b0;
        forever #5 pixel_clock = ~pixel_clock;
    end

    // Synchronous single-port RAM with a preload port for the bench
    logic [7:0]  mem [0:8191];
    logic        ram_load;
    logic [12:0] load_addr;
    logic [7:0]  load_data;
    always @(posedge pixel_clock) begin
        if (ram_load) begin
            mem[load_addr] <= load_data;
        end else begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            vram_rdata <= mem[vram_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        fen;
        logic        req;
        logic        we;
        logic [2:0]  ph;
        logic        vwe;
        logic        fv;
        logic        ack;
        logic        achk;
        logic [12:0] addr;
        logic [7:0]  fdata;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tbl [56];

    // reference model state
    logic [7:0]  ref_mem [0:8191];
    int          ref_phase;
    logic        q_we [8];
    logic [7:0]  q_wd [8];
    logic        q_av [8];
    logic [12:0] q_addr [8];
    logic        q_fv [8];
    logic [7:0]  q_fd [8];
    logic        q_ack [8];
    logic        q_rdu [8];
    logic [7:0]  q_rd [8];
    logic [7:0]  exp_fdata;
    logic [7:0]  exp_rdata;

    initial begin
        int  raise_cyc;
        logic req_open;
        logic drop_next;
        logic sync_seen;

        reset = 1'b1; phase_sync = 1'b0; fetch_en = 1'b0; fetch_addr = 13'h0000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000; cpu_wdata = 8'h00;
        ram_load = 1'b1; load_addr = 13'h0123; load_data = 8'h5A;
        @(negedge pixel_clock);
        load_addr = 13'h0456; load_data = 8'h3C;
        @(negedge pixel_clock);
        ram_load = 1'b0;
        @(negedge pixel_clock);

        // directed cycle table, row k = cycle k after reset release
        for (int k = 0; k < 56; k++) begin
            tbl[k] = '{default: '0};
            tbl[k].ph = 3'(k % 8);
            if ((k >= 16 && k <= 31) || k >= 40) tbl[k].fen = 1'b1;
            if (k >= 32 && k <= 35) begin tbl[k].req = 1'b1; tbl[k].we = 1'b1; end
            if ((k >= 36 && k <= 39) || k >= 45) tbl[k].req = 1'b1;
        end
        foreach (tbl[k]) begin
            if (k == 17 || k == 25 || k == 41 || k == 49) begin
                tbl[k].achk = 1'b1; tbl[k].addr = 13'h0123;
            end
            if (k == 19 || k == 27 || k == 43 || k == 51) begin
                tbl[k].fv = 1'b1; tbl[k].fdata = 8'h5A;
            end
        end
        tbl[33].vwe = 1'b1; tbl[33].achk = 1'b1; tbl[33].addr = 13'h1FFF;
        tbl[35].ack = 1'b1; tbl[35].rdata = 8'h00;
        tbl[37].achk = 1'b1; tbl[37].addr = 13'h1FFF;
        tbl[39].ack = 1'b1; tbl[39].rdata = 8'hA5;
        tbl[53].achk = 1'b1; tbl[53].addr = 13'h1FFF;
        tbl[55].ack = 1'b1; tbl[55].rdata = 8'hA5;

        reset = 1'b0;
        chk("reset_vram_addr", vram_addr, 13'h0000);
        chk("reset_vram_wdata", vram_wdata, 8'h00);
        chk("reset_fetch_data", fetch_data, 8'h00);
        chk("reset_cpu_rdata", cpu_rdata, 8'h00);
        raise_cyc = 0; req_open = 1'b0;
        for (int k = 0; k < 56; k++) begin
            chk("tbl_phase", phase, tbl[k].ph);
            chk("tbl_vram_we", vram_we, tbl[k].vwe);
            chk("tbl_fetch_valid", fetch_valid, tbl[k].fv);
            chk("tbl_cpu_ack", cpu_ack, tbl[k].ack);
            if (tbl[k].achk) chk("tbl_vram_addr", vram_addr, tbl[k].addr);
            if (tbl[k].vwe) chk("tbl_vram_wdata", vram_wdata, 8'hA5);
            if (tbl[k].fv) chk("tbl_fetch_data", fetch_data, tbl[k].fdata);
            if (tbl[k].ack) begin
                chk("tbl_cpu_rdata", cpu_rdata, tbl[k].rdata);
                chk("tbl_ack_latency", 32'((k - raise_cyc) <= 11), 32'd1);
                req_open = 1'b0;
            end
            if (tbl[k].req && !req_open && !tbl[k].ack) begin
                raise_cyc = k; req_open = 1'b1;
            end
            fetch_en = tbl[k].fen; fetch_addr = 13'h0123;
            cpu_req = tbl[k].req; cpu_we = tbl[k].we;
            cpu_addr = 13'h1FFF; cpu_wdata = 8'hA5;
            @(negedge pixel_clock);
        end

        // phase_sync in phase 2 of a display fetch (cycle 56 is phase 0)
        fetch_en = 1'b1; fetch_addr = 13'h0123; cpu_req = 1'b0;
        @(negedge pixel_clock);
        @(negedge pixel_clock);
        chk("sync_pre_phase", phase, 3'd2);
        phase_sync = 1'b1;
        @(negedge pixel_clock);
        chk("sync_phase0", phase, 3'd0);
        chk("sync_fetch_valid", fetch_valid, 1'b1);
        chk("sync_fetch_data", fetch_data, 8'h5A);
        phase_sync = 1'b0; fetch_addr = 13'h0456;
        @(negedge pixel_clock);
        chk("sync_new_phase1", phase, 3'd1);
        chk("sync_new_addr", vram_addr, 13'h0456);
        @(negedge pixel_clock);
        chk("sync_no_strobe", fetch_valid, 1'b0);
        @(negedge pixel_clock);
        chk("sync_new_phase3", phase, 3'd3);
        chk("sync_new_valid", fetch_valid, 1'b1);
        chk("sync_new_data", fetch_data, 8'h3C);

        // reset asserted in the phase-5 cycle of a CPU write
        fetch_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0AAA; cpu_wdata = 8'h77;
        @(negedge pixel_clock);
        chk("rst_pre_phase4", phase, 3'd4);
        @(negedge pixel_clock);
        chk("rst_wr_phase5", phase, 3'd5);
        chk("rst_wr_we", vram_we, 1'b1);
        chk("rst_wr_addr", vram_addr, 13'h0AAA);
        chk("rst_wr_wdata", vram_wdata, 8'h77);
        #2 reset = 1'b1;
        #1;
        chk("rst_we_drop", vram_we, 1'b0);
        chk("rst_phase", phase, 3'd0);
        chk("rst_addr", vram_addr, 13'h0000);
        chk("rst_wdata", vram_wdata, 8'h00);
        chk("rst_fetch_data", fetch_data, 8'h00);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_fetch_valid", fetch_valid, 1'b0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (3) @(negedge pixel_clock);
        reset = 1'b0;

        // randomized traffic against the slot-schedule model
        for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 8; i++) begin
            q_we[i] = 1'b0; q_av[i] = 1'b0; q_fv[i] = 1'b0; q_ack[i] = 1'b0; q_rdu[i] = 1'b0;
        end
        ref_phase = 0; exp_fdata = 8'h00; exp_rdata = 8'h00;
        drop_next = 1'b0; sync_seen = 1'b0; raise_cyc = 0;
        for (int n = 0; n < 1500; n++) begin
            int s;
            int s1;
            int s3;
            s = n % 8; s1 = (n + 1) % 8; s3 = (n + 3) % 8;
            if (q_fv[s]) exp_fdata = q_fd[s];
            if (q_rdu[s]) exp_rdata = q_rd[s];
            chk("rnd_phase", phase, 32'(ref_phase));
            chk("rnd_vram_we", vram_we, q_we[s]);
            chk("rnd_fetch_valid", fetch_valid, q_fv[s]);
            chk("rnd_cpu_ack", cpu_ack, q_ack[s]);
            chk("rnd_fetch_data", fetch_data, exp_fdata);
            chk("rnd_cpu_rdata", cpu_rdata, exp_rdata);
            if (q_av[s]) chk("rnd_vram_addr", vram_addr, q_addr[s]);
            if (q_we[s]) chk("rnd_vram_wdata", vram_wdata, q_wd[s]);
            q_we[s] = 1'b0; q_av[s] = 1'b0; q_fv[s] = 1'b0; q_ack[s] = 1'b0; q_rdu[s] = 1'b0;

            // CPU requester: holds the request until ack, drops it after the ack cycle
            if (cpu_req && cpu_ack) begin
                if (!sync_seen) chk("rnd_ack_latency", 32'((n - raise_cyc) <= 11), 32'd1);
                drop_next = 1'b1;
            end else if (drop_next) begin
                cpu_req = 1'b0; drop_next = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 13'h0120 + 13'($urandom_range(0, 7));
                cpu_wdata = 8'($urandom);
                raise_cyc = n; sync_seen = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) fetch_en = 1'($urandom_range(0, 1));
            fetch_addr = 13'h0120 + 13'($urandom_range(0, 7));
            phase_sync = ($urandom_range(0, 63) == 0);
            if (phase_sync) sync_seen = 1'b1;

            // slot rules: display takes phase 0 windows when enabled, CPU takes the rest
            if (ref_phase == 0 && fetch_en) begin
                q_av[s1] = 1'b1; q_addr[s1] = fetch_addr;
                q_fv[s3] = 1'b1; q_fd[s3] = ref_mem[fetch_addr];
            end else if ((ref_phase == 0 || ref_phase == 4) && cpu_req) begin
                q_av[s1] = 1'b1; q_addr[s1] = cpu_addr;
                q_ack[s3] = 1'b1;
                if (cpu_we) begin
                    q_we[s1] = 1'b1; q_wd[s1] = cpu_wdata;
                    ref_mem[cpu_addr] = cpu_wdata;
                end else begin
                    q_rdu[s3] = 1'b1; q_rd[s3] = ref_mem[cpu_addr];
                end
            end
            ref_phase = phase_sync ? 0 : (ref_phase + 1) % 8;
            @(negedge pixel_clock);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
